// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared state encoding for the systolic array sequencer
package systolic_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_CLEAR = 3'd1;
    localparam state_t S_FEED  = 3'd2;
    localparam state_t S_DRAIN = 3'd3;
    localparam state_t S_DONE  = 3'd4;

endpackage

// File: rtl/skew_shift.sv
// rtl/skew_shift.sv - shift register producing one-cycle-per-lane skewed enables
module skew_shift #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         in_bit,
    output logic [W-1:0] shift
);

    // Lane i repeats lane 0 delayed by i cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift <= '0;
        end else if (clr) begin
            shift <= '0;
        end else begin
            shift <= {shift[W-2:0], in_bit};
        end
    end

endmodule

// File: rtl/systolic_sequencer.sv
// rtl/systolic_sequencer.sv - job sequencer: clear, skewed operand feed, drain, result handshake
module systolic_sequencer
    import systolic_pkg::*;
#(
    parameter int N  = 2,
    parameter int M  = 2,
    parameter int KW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [KW-1:0] cmd_k,
    input  logic          abort,
    output logic          acc_clr,
    output logic [N-1:0]  a_en,
    output logic [M-1:0]  b_en,
    output logic [KW-1:0] rd_addr,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          busy
);

    localparam int DW = $clog2(N + M);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(N + M - 2);

    state_t        state;
    state_t        state_next;
    logic [KW-1:0] k_reg;
    logic [KW-1:0] k_cnt;
    logic [DW-1:0] d_cnt;
    logic          feed_next;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (cmd_valid) state_next = S_CLEAR;
            S_CLEAR: state_next = (k_reg == '0) ? S_DONE : S_FEED;
            S_FEED:  if (k_cnt == k_reg - KW'(1)) state_next = S_DRAIN;
            S_DRAIN: if (d_cnt == DRAIN_LAST) state_next = S_DONE;
            S_DONE:  if (res_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (abort && state != S_IDLE) begin
            state_next = S_IDLE;
        end
    end

    // Lane 0 is registered from the next state so every enable comes straight off a flop.
    assign feed_next = (state_next == S_FEED);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            k_reg <= '0;
            k_cnt <= '0;
            d_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && cmd_valid) begin
                k_reg <= cmd_k;
            end
            k_cnt <= (state == S_FEED && state_next == S_FEED) ? k_cnt + KW'(1) : '0;
            d_cnt <= (state == S_DRAIN && state_next == S_DRAIN) ? d_cnt + DW'(1) : '0;
        end
    end

    skew_shift #(.W(N)) u_a_skew (
        .clk    (clk),
        .rst    (rst),
        .clr    (abort),
        .in_bit (feed_next),
        .shift  (a_en)
    );

    skew_shift #(.W(M)) u_b_skew (
        .clk    (clk),
        .rst    (rst),
        .clr    (abort),
        .in_bit (feed_next),
        .shift  (b_en)
    );

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign acc_clr   = (state == S_CLEAR);
    assign res_valid = (state == S_DONE);
    assign rd_addr   = (state == S_FEED) ? k_cnt : '0;

endmodule

// File: tb/tb_systolic_sequencer.sv
// tb/tb_systolic_sequencer.sv - randomized self-checking bench for systolic_sequencer
module tb_systolic_sequencer;

    localparam int N  = 2;
    localparam int M  = 2;
    localparam int KW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [KW-1:0] cmd_k;
    logic          abort;
    logic          acc_clr;
    logic [N-1:0]  a_en;
    logic [M-1:0]  b_en;
    logic [KW-1:0] rd_addr;
    logic          res_valid;
    logic          res_ready;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    systolic_sequencer #(.N(N), .M(M), .KW(KW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_k     (cmd_k),
        .abort     (abort),
        .acc_clr   (acc_clr),
        .a_en      (a_en),
        .b_en      (b_en),
        .rd_addr   (rd_addr),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_acc_clr"}, 32'(acc_clr), 32'd0);
        check({tag, "_a_en"}, 32'(a_en), 32'd0);
        check({tag, "_b_en"}, 32'(b_en), 32'd0);
        check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    function automatic int done_cycle(input int k);
        return (k == 0) ? 2 : 2 + k + N + M - 1;
    endfunction

    // Called at a negedge while IDLE. Cycle c counts from the accept edge: c=1 is the clear
    // cycle, c=2 the first feed cycle. ab>0 aborts during cycle ab; rdly delays res_ready.
    task automatic run_job(input int k, input int ab, input int rdly, input bit hold);
        int done_c;
        int end_c;
        int t;
        logic [N-1:0]  ea;
        logic [M-1:0]  eb;
        logic [KW-1:0] er;
        check("start_cmd_ready", 32'(cmd_ready), 32'd1);
        check("start_busy", 32'(busy), 32'd0);
        cmd_valid = 1'b1;
        cmd_k     = KW'(k);
        abort     = 1'($urandom_range(0, 1));
        res_ready = 1'($urandom_range(0, 1));
        done_c = done_cycle(k);
        end_c  = (ab > 0) ? ab + 1 : done_c + rdly + 1;
        for (int c = 1; c <= end_c; c++) begin
            @(negedge clk);
            if (c == end_c) begin
                check_idle((ab > 0) ? "post_abort" : "post_done");
                cmd_valid = hold;
                abort     = 1'b0;
                res_ready = 1'b0;
            end else begin
                t = c - 2;
                for (int i = 0; i < N; i++) ea[i] = (t >= i) && (t < i + k);
                for (int j = 0; j < M; j++) eb[j] = (t >= j) && (t < j + k);
                er = (t >= 0 && t < k) ? KW'(t) : '0;
                check("acc_clr", 32'(acc_clr), 32'(c == 1));
                check("a_en", 32'(a_en), 32'(ea));
                check("b_en", 32'(b_en), 32'(eb));
                check("rd_addr", 32'(rd_addr), 32'(er));
                check("res_valid", 32'(res_valid), 32'(c >= done_c));
                check("busy", 32'(busy), 32'd1);
                check("cmd_ready", 32'(cmd_ready), 32'd0);
                cmd_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
                cmd_k     = KW'($urandom);
                abort     = (c == ab);
                res_ready = (c < done_c) ? 1'($urandom_range(0, 1)) : (c >= done_c + rdly);
            end
        end
    endtask

    initial begin
        int k;
        int ab;
        int rdly;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_k     = '0;
        abort     = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b1;
        @(negedge clk);
        check_idle("after_reset");

        run_job(3, 0, 0, 1'b0);
        run_job(0, 0, 1, 1'b0);
        run_job(4, 3, 0, 1'b0);
        run_job(1, 0, 0, 1'b0);
        run_job(2, 0, 0, 1'b1);
        run_job(2, 0, 5, 1'b1);
        run_job(3, 0, 2, 1'b0);
        run_job(2, 1, 0, 1'b0);
        run_job(2, 5, 0, 1'b0);
        run_job(1, 7, 3, 1'b0);
        run_job(255, 0, 1, 1'b0);

        for (int n = 0; n < 12; n++) begin
            k    = int'($urandom_range(0, 20));
            rdly = int'($urandom_range(0, 4));
            ab   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, done_cycle(k) + rdly)) : 0;
            run_job(k, ab, rdly, 1'b0);
        end

        // Reset asserted mid-feed discards the job.
        cmd_valid = 1'b1;
        cmd_k     = KW'(5);
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        check("pre_reset_busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1 check_idle("async_reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset_held");
        rst = 1'b1;
        @(negedge clk);
        check_idle("reset_release");
        run_job(2, 0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
